// File: rtl/data_memory.sv
// Line-granular data memory responder for the 256-bit data-cache interface.
// One request at a time, completed after LATENCY cycles with a one-cycle ack.
module data_memory #(
    parameter int LATENCY = 10,
    parameter int ADDR_W  = 9
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         enable_i,
    input  logic         write_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    output logic         ack_o,
    output logic [255:0] data_o
);

    localparam int        DEPTH  = 2 ** ADDR_W;
    localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic                wr_q, wr_d;
    logic [255:0]        line_q, line_d;
    logic                ack_q, ack_d;
    logic [255:0]        rdata_q, rdata_d;
    logic                mem_we_s;
    logic                unused_addr_s;

    logic [255:0]        mem_q [DEPTH];

    // Offset and high address bits alias onto the same line.
    assign unused_addr_s = ^{addr_i[31:ADDR_W+5], addr_i[4:0]};

    // Next-state logic: latch in IDLE, count down in WAIT, abort on dropped enable.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        wr_d     = wr_q;
        line_d   = line_q;
        rdata_d  = rdata_q;
        ack_d    = 1'b0;
        mem_we_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable_i) begin
                    idx_d   = addr_i[ADDR_W+4:5];
                    wr_d    = write_i;
                    line_d  = data_i;
                    cnt_d   = LAT_M1;
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!enable_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 8'd0) begin
                    ack_d   = 1'b1;
                    state_d = ST_ACK;
                    if (wr_q) begin
                        mem_we_s = 1'b1;
                    end else begin
                        rdata_d = mem_q[idx_q];
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and output registers; the storage array is deliberately not reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            line_q  <= 256'd0;
            ack_q   <= 1'b0;
            rdata_q <= 256'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            line_q  <= line_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
        end
    end

    // Line array, written only on the completion edge of a write.
    always_ff @(posedge clk_i) begin
        if (mem_we_s) begin
            mem_q[idx_q] <= line_q;
        end
    end

    assign ack_o  = ack_q;
    assign data_o = rdata_q;

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: vector table plus scoreboard on acks,
// with hand sequences for chaining, abort, reset mid-write and LATENCY=1.
module tb_data_memory;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable_i, write_i;
    logic [31:0]  addr_i;
    logic [255:0] data_i;
    logic         ack_o;
    logic [255:0] data_o;

    logic         en1, wr1;
    logic [31:0]  addr1;
    logic [255:0] din1;
    logic         ack1;
    logic [255:0] q1;

    int total = 0;
    int bad   = 0;
    int ack_cnt = 0;

    typedef struct {
        logic         is_rd;
        logic [255:0] data;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
        logic [255:0] exp;
    } vec_t;
    vec_t vecs[12];

    localparam logic [255:0] VA5  = {8{32'h5A5A_A5A5}};
    localparam logic [255:0] VDB  = {8{32'hDEAD_BEEF}};
    localparam logic [255:0] V1   = {4{64'h0123_4567_89AB_CDEF}};
    localparam logic [255:0] V8   = {8{32'h0808_0808}};
    localparam logic [255:0] V9   = {8{32'h9999_0009}};
    localparam logic [255:0] VMX  = {8{32'hFFFF_0001}};
    localparam logic [255:0] VNEW = {8{32'hC0FF_EE00}};
    localparam logic [255:0] W4   = {8{32'h4004_0404}};
    localparam logic [255:0] JUNK = {8{32'h1BAD_1BAD}};

    data_memory #(.LATENCY(10), .ADDR_W(9)) dut (
        .clk_i(clk), .rst_i(rst_n), .enable_i(enable_i), .write_i(write_i),
        .addr_i(addr_i), .data_i(data_i), .ack_o(ack_o), .data_o(data_o)
    );

    data_memory #(.LATENCY(1), .ADDR_W(9)) dut1 (
        .clk_i(clk), .rst_i(rst_n), .enable_i(en1), .write_i(wr1),
        .addr_i(addr1), .data_i(din1), .ack_o(ack1), .data_o(q1)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Scoreboard: every ack must match the oldest outstanding request.
    always @(negedge clk) begin
        if (ack_o === 1'b1) begin
            exp_t e;
            ack_cnt++;
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ack: got ack with empty queue, want none");
            end else begin
                e = sb_q.pop_front();
                if (e.is_rd) check_vec("sb_read_data", data_o, e.data);
            end
        end
    end

    // Called 1ns after a rising edge with the main DUT idle.
    task automatic do_req(input logic wr, input logic [31:0] a, input logic [255:0] d,
                          input logic [255:0] exp, input bit keep);
        int k;
        enable_i = 1'b1; write_i = wr; addr_i = a; data_i = d;
        sb_q.push_back('{!wr, exp});
        @(posedge clk);
        k = 0;
        do begin
            @(posedge clk); #1; k++;
        end while (ack_o !== 1'b1 && k < 300);
        check_int("latency10", k, 10);
        if (!keep) enable_i = 1'b0;
        @(posedge clk); #1;
        check_vec("ack_fall", {255'd0, ack_o}, 256'd0);
        if (!wr) check_vec("data_hold", data_o, exp);
    endtask

    task automatic do_req1(input logic wr, input logic [31:0] a, input logic [255:0] d,
                           input logic [255:0] exp);
        int k;
        en1 = 1'b1; wr1 = wr; addr1 = a; din1 = d;
        @(posedge clk);
        k = 0;
        do begin
            @(posedge clk); #1; k++;
        end while (ack1 !== 1'b1 && k < 300);
        check_int("latency1", k, 1);
        if (!wr) check_vec("lat1_read", q1, exp);
        en1 = 1'b0;
        @(posedge clk); #1;
        check_vec("lat1_ack_fall", {255'd0, ack1}, 256'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        vecs[0]  = '{1'b1, 32'h0000_0060, VA5,  256'd0};
        vecs[1]  = '{1'b1, 32'h0000_00A0, VDB,  256'd0};
        vecs[2]  = '{1'b1, 32'h0000_0020, V1,   256'd0};
        vecs[3]  = '{1'b1, 32'h0000_0100, V8,   256'd0};
        vecs[4]  = '{1'b1, 32'h0000_0120, V9,   256'd0};
        vecs[5]  = '{1'b1, 32'h0000_3FE0, VMX,  256'd0};
        vecs[6]  = '{1'b0, 32'h0000_0060, JUNK, VA5};
        vecs[7]  = '{1'b0, 32'h0000_00A4, JUNK, VDB};
        vecs[8]  = '{1'b0, 32'h0000_4060, JUNK, VA5};
        vecs[9]  = '{1'b0, 32'h0000_7FE0, JUNK, VMX};
        vecs[10] = '{1'b1, 32'h0000_0060, VNEW, 256'd0};
        vecs[11] = '{1'b0, 32'h0000_0060, JUNK, VNEW};

        rst_n = 1'b0;
        enable_i = 1'b0; write_i = 1'b0; addr_i = 32'd0; data_i = 256'd0;
        en1 = 1'b0; wr1 = 1'b0; addr1 = 32'd0; din1 = 256'd0;
        repeat (2) @(posedge clk);
        #1;
        check_vec("rst_ack", {255'd0, ack_o}, 256'd0);
        check_vec("rst_data", data_o, 256'd0);
        check_vec("rst_ack1", {255'd0, ack1}, 256'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++)
            do_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp, 1'b0);

        // Writeback chained into a line fill, enable held high through ACK.
        a0 = ack_cnt;
        do_req(1'b1, 32'h0000_0400, W4, 256'd0, 1'b1);
        do_req(1'b0, 32'h0000_0020, JUNK, V1, 1'b0);
        repeat (15) @(posedge clk);
        #1;
        check_int("chain_two_acks", ack_cnt - a0, 2);
        do_req(1'b0, 32'h0000_0400, JUNK, W4, 1'b0);

        // Abort: enable dropped so that the 4th edge of WAIT sees it low.
        a0 = ack_cnt;
        enable_i = 1'b1; write_i = 1'b1; addr_i = 32'h0000_0100; data_i = JUNK;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1 enable_i = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check_int("abort_no_ack", ack_cnt - a0, 0);
        do_req(1'b0, 32'h0000_0100, JUNK, V8, 1'b0);

        // Reset at edge 6 of a write: outputs clear at once, line untouched.
        enable_i = 1'b1; write_i = 1'b1; addr_i = 32'h0000_0120; data_i = JUNK;
        @(posedge clk);
        repeat (6) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_vec("midrst_ack", {255'd0, ack_o}, 256'd0);
        check_vec("midrst_data", data_o, 256'd0);
        enable_i = 1'b0;
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        do_req(1'b0, 32'h0000_0120, JUNK, V9, 1'b0);
        check_int("sb_empty", sb_q.size(), 0);

        // LATENCY=1 instance with address aliasing.
        do_req1(1'b1, 32'h0000_0060, VDB, 256'd0);
        do_req1(1'b0, 32'h0000_4060, JUNK, VDB);
        do_req1(1'b1, 32'h0000_0060, V1, 256'd0);
        do_req1(1'b0, 32'h0000_0060, JUNK, V1);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_memory.md
# data_memory

Line-granular data memory model that serves as the responder on the 256-bit data-memory interface driven by the data cache controller. It accepts one read or write request at a time, holds it for a fixed programmable latency, then completes it with a single-cycle acknowledge. Reads return a full 32-byte line; writes replace a full line. It sits below the data cache in the CPU top level and in cache-only benches.

## Interface
- LATENCY, 10, cycles from request sampling edge to the ack rising edge; legal range 1..255.
- ADDR_W, 9, line-index width; DEPTH = 2**ADDR_W lines (default 512 lines = 16 KB).

- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  reset; asynchronous, active-low.
- enable_i  input  1  request valid; initiator holds it high until it sees ack_o.
- write_i  input  1  1 = line write, 0 = line read; sampled with the request.
- addr_i  input  32  byte address; line index = addr_i[ADDR_W+4:5]; bits [4:0] and bits above ADDR_W+4 ignored (aliasing).
- data_i  input  256  write line; sampled with the request.
- ack_o  output  1  completion strobe, exactly one cycle per completed request.
- data_o  output  256  read line; valid while ack_o=1 and held until the next read completes.

## Operation
- Storage: DEPTH x 256-bit array, not cleared by reset; benches preload it.
- States: IDLE, WAIT, ACK (registered; ack_o is a registered output).
- IDLE: at a rising edge with enable_i=1, latch line index, write_i and data_i; load counter with LATENCY-1; go to WAIT. enable_i=0: stay.
- WAIT: at each edge, if enable_i=0, abort: go to IDLE, no array update, no ack. Else if counter=0: perform operation, ack_o<=1, go to ACK. Else decrement counter.
- Operation at completion edge: write -> array[idx] <= latched data; data_o unchanged. Read -> data_o <= array[idx].
- ACK: at next edge ack_o<=0, go to IDLE; inputs ignored in this state.
- Changes to addr_i, write_i, data_i during WAIT are ignored (latched values used).
- Counter width 8 bits; never wraps (loaded only in IDLE, stops at 0).

## Timing
- Request sampled at edge E0; ack_o high from edge E0+LATENCY to E0+LATENCY+1; earliest next sampling edge E0+LATENCY+2.
- LATENCY=1: ack at E0+1.
- Back-to-back: initiator that keeps enable_i high through ACK (writeback then line fill, write_i falling and addr_i changing at E0+LATENCY+1) has its new request sampled at E0+LATENCY+2; no request is lost or doubled.
- Initiator that drops enable_i at E0+LATENCY+1 produces no further request.
- Read-after-write to the same line returns the written data (array updated at the write's ack edge).
- Reset (any time, including mid-WAIT or during ACK): state=IDLE, ack_o=0, data_o=0, counter=0; a pending write is discarded; array contents retained.

## Test plan
- Read, LATENCY=10: preload line 3 = 256'h…A5A5, enable_i=1, write_i=0, addr_i=32'h0000_0060 at edge 0 -> ack_o high exactly edges 10-11, data_o=preloaded value, held after ack falls.
- Write then read: write line 5 (addr 32'h0000_00A0) with 256'hDEAD…BEEF -> ack at +10; then read addr 32'h0000_00A4 (same line, offset ignored) -> data_o=256'hDEAD…BEEF.
- Writeback chained to fill: write addr 32'h0000_0400 kept enable high, switch to read addr 32'h0000_0020 at the edge after ack -> exactly two acks, second 10 cycles after the sampling edge following ACK; line 0x400>>5 holds written data.
- Abort: drop enable_i at edge 4 of WAIT -> no ack ever, target line unchanged, next request serviced normally.
- Reset mid-write: assert rst_i=0 at edge 6 of a write -> ack_o=0, data_o=0 immediately; target line unchanged after release.
- LATENCY=1 and aliasing: ack one edge after sampling; addr 32'h0000_4060 (ADDR_W=9) reads same line as 32'h0000_0060.
